// File: rtl/dcache_tb_pkg.sv
// Shared types and helpers for the Dcache sequence tester: FSM states,
// LFSR step function and byte-masked data compare.
package dcache_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RWAIT,
    S_DONE
  } state_e;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_LFSR_SEED = 32'hACE1_2345;

  // Widest data bus the compare helper accepts; callers zero-extend.
  localparam int MAX_DATA_W = 512;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic masked_mismatch(input logic [MAX_DATA_W-1:0]   a,
                                           input logic [MAX_DATA_W-1:0]   b,
                                           input logic [MAX_DATA_W/8-1:0] sel);
    logic [MAX_DATA_W-1:0] diff;
    diff            = a ^ b;
    masked_mismatch = 1'b0;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (sel[i] && (diff[8*i +: 8] != 8'h00)) masked_mismatch = 1'b1;
    end
  endfunction

endpackage

// File: rtl/dcache_seq_tester_lfsr32.sv
// 32-bit Galois LFSR with synchronous reseed; reset also loads the seed.
module lfsr32
  import dcache_tb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] q_q;
  logic [31:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load)      q_d = seed;
    else if (step) q_d = lfsr_next(q_q);
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= seed;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/dcache_seq_tester.sv
// Dcache bring-up traffic generator/checker: writes LFSR data to a strided
// range, reads it back through a stall/rvalid handshake and scores mismatches.
module dcache_seq_tester
  import dcache_tb_pkg::*;
#(
  parameter int                   DATA_W      = 32,
  parameter int                   ADDR_W      = 32,
  parameter int                   N_ENTRIES   = 16,
  parameter logic [ADDR_W-1:0]    ADDR_BASE   = '0,
  parameter int                   ADDR_STRIDE = 16,
  parameter logic [DATA_W/8-1:0]  SEL_MASK    = '1,
  parameter logic [31:0]          LFSR_SEED   = DEFAULT_LFSR_SEED,
  parameter int                   RD_TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                mode_i,
  input  logic                dcache_stall_i,
  input  logic                dcache_rvalid_i,
  input  logic [DATA_W-1:0]   dcache_data_i,
  output logic [ADDR_W-1:0]   dcache_waddr_o,
  output logic [DATA_W-1:0]   dcache_wdata_o,
  output logic                dcache_wreq_o,
  output logic [ADDR_W-1:0]   dcache_raddr_o,
  output logic                dcache_rreq_o,
  output logic [DATA_W/8-1:0] dcache_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [15:0]         first_fail_idx_o
);

  localparam int SEL_W = DATA_W / 8;
  localparam int IDX_W = $clog2(N_ENTRIES + 1);
  localparam int TMO_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  function automatic logic [DATA_W-1:0] expand(input logic [31:0] s);
    for (int i = 0; i < DATA_W; i++) expand[i] = s[i % 32];
  endfunction

  function automatic logic [ADDR_W-1:0] entry_addr(input logic [IDX_W-1:0] idx);
    return ADDR_BASE + ADDR_W'(idx) * ADDR_W'(ADDR_STRIDE);
  endfunction

  state_e              state_q, state_d;
  logic                mode_q, mode_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                wreq_q, wreq_d;
  logic                rreq_q, rreq_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [15:0]         err_q, err_d;
  logic [15:0]         ff_q, ff_d;

  logic        gen_load, chk_load, chk_step, wr_acc;
  logic        rd_done, rd_tmo, rd_err;
  logic [31:0] gen_q, chk_q;

  assign wr_acc   = wreq_q & ~dcache_stall_i;
  assign rd_done  = (state_q == S_RWAIT) & dcache_rvalid_i;
  assign rd_tmo   = (state_q == S_RWAIT) & ~dcache_rvalid_i & (tmo_q == TMO_LAST);
  assign chk_step = rd_done | rd_tmo;
  assign rd_err   = rd_tmo |
                    (rd_done & masked_mismatch(MAX_DATA_W'(dcache_data_i),
                                               MAX_DATA_W'(expand(chk_q)),
                                               (MAX_DATA_W/8)'(SEL_MASK)));

  lfsr32 u_gen (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load),
    .seed (LFSR_SEED),
    .step (wr_acc),
    .q    (gen_q)
  );

  lfsr32 u_chk (
    .clk  (clk),
    .rst  (rst),
    .load (chk_load),
    .seed (LFSR_SEED),
    .step (chk_step),
    .q    (chk_q)
  );

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path leaves it unassigned
    // and no latch is inferred.
    state_d  = state_q;
    mode_d   = mode_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    wreq_d   = wreq_q;
    rreq_d   = rreq_q;
    waddr_d  = waddr_q;
    raddr_d  = raddr_q;
    wdata_d  = wdata_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    gen_load = 1'b0;
    chk_load = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d  = S_WR;
          mode_d   = mode_i;
          idx_d    = '0;
          err_d    = '0;
          ff_d     = 16'hFFFF;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          gen_load = 1'b1;
          chk_load = 1'b1;
        end
      end
      // Each request is raised from an idle cycle so it always drops after acceptance.
      S_WR: begin
        if (!wreq_q) begin
          wreq_d  = 1'b1;
          waddr_d = entry_addr(idx_q);
          wdata_d = expand(gen_q);
          sel_d   = SEL_MASK;
        end else if (!dcache_stall_i) begin
          wreq_d = 1'b0;
          if (!mode_q) begin
            state_d = S_RD;
          end else if (idx_q == LAST_IDX) begin
            state_d = S_RD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_RD: begin
        if (!rreq_q) begin
          rreq_d  = 1'b1;
          raddr_d = entry_addr(idx_q);
          sel_d   = SEL_MASK;
        end else if (!dcache_stall_i) begin
          rreq_d  = 1'b0;
          tmo_d   = '0;
          state_d = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (rd_done || rd_tmo) begin
          if (rd_err) begin
            err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            if (ff_q == 16'hFFFF) ff_d = 16'(idx_q);
          end
          // NOTE: blocking assignments here, so pass_d sees the err_d just computed.
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 16'd0);
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = mode_q ? S_RD : S_WR;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      tmo_q   <= '0;
      wreq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= 16'hFFFF;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      wreq_q  <= wreq_d;
      rreq_q  <= rreq_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  assign dcache_waddr_o   = waddr_q;
  assign dcache_wdata_o   = wdata_q;
  assign dcache_wreq_o    = wreq_q;
  assign dcache_raddr_o   = raddr_q;
  assign dcache_rreq_o    = rreq_q;
  assign dcache_sel_o     = sel_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_fail_idx_o = ff_q;

endmodule

// File: tb/tb_dcache_seq_tester.sv
// Directed bench: a cache model answers requests, a scoreboard holds the
// expected request stream, and final status is checked after every run.
module tb_dcache_seq_tester;

  localparam int          N    = 16;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, mode = 1'b0;
  logic stall = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;

  logic [31:0] waddr, wdata, raddr;
  logic        wreq, rreq, busy, done, pass;
  logic [3:0]  sel;
  logic [15:0] err_count, ff_idx;

  logic [31:0] m_waddr, m_wdata, m_raddr;
  logic        m_wreq, m_rreq, m_busy, m_done, m_pass;
  logic [3:0]  m_sel;
  logic [15:0] m_err_count, m_ff_idx;

  logic        rvalid1 = 1'b0;
  logic [31:0] rdata1 = '0;
  logic [31:0] waddr1, wdata1, raddr1;
  logic        wreq1, rreq1, busy1, done1, pass1;
  logic [3:0]  sel1;
  logic [15:0] err_count1, ff_idx1;

  always #5 clk = ~clk;

  dcache_seq_tester dut (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .dcache_stall_i(stall), .dcache_rvalid_i(rvalid), .dcache_data_i(rdata),
    .dcache_waddr_o(waddr), .dcache_wdata_o(wdata), .dcache_wreq_o(wreq),
    .dcache_raddr_o(raddr), .dcache_rreq_o(rreq), .dcache_sel_o(sel),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_count_o(err_count), .first_fail_idx_o(ff_idx)
  );

  // Same traffic as dut, but only the low two byte lanes are compared.
  dcache_seq_tester #(.SEL_MASK(4'b0011)) dut_m (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .dcache_stall_i(stall), .dcache_rvalid_i(rvalid), .dcache_data_i(rdata),
    .dcache_waddr_o(m_waddr), .dcache_wdata_o(m_wdata), .dcache_wreq_o(m_wreq),
    .dcache_raddr_o(m_raddr), .dcache_rreq_o(m_rreq), .dcache_sel_o(m_sel),
    .busy_o(m_busy), .done_o(m_done), .pass_o(m_pass),
    .err_count_o(m_err_count), .first_fail_idx_o(m_ff_idx)
  );

  dcache_seq_tester #(.N_ENTRIES(1), .ADDR_BASE(32'h100)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .mode_i(mode),
    .dcache_stall_i(1'b0), .dcache_rvalid_i(rvalid1), .dcache_data_i(rdata1),
    .dcache_waddr_o(waddr1), .dcache_wdata_o(wdata1), .dcache_wreq_o(wreq1),
    .dcache_raddr_o(raddr1), .dcache_rreq_o(rreq1), .dcache_sel_o(sel1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1),
    .err_count_o(err_count1), .first_fail_idx_o(ff_idx1)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference generator written from the polynomial x^32+x^22+x^2+x+1.
  function automatic logic [31:0] ref_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  task automatic push_run(input bit burst);
    logic [31:0] s;
    s = SEED;
    for (int i = 0; i < N; i++) begin
      sb.push_back('{1'b1, 32'(i * 16), s});
      if (!burst) sb.push_back('{1'b0, 32'(i * 16), 32'h0});
      s = ref_next(s);
    end
    if (burst) for (int i = 0; i < N; i++) sb.push_back('{1'b0, 32'(i * 16), 32'h0});
  endtask

  // Cache model state.
  logic [31:0] mem[logic [31:0]];
  bit          stall_en = 1'b0;
  bit          in_req = 1'b0, pend = 1'b0, tmo_watch = 1'b0;
  int          stall_left = 0, req_num = 0, rd_cnt = 0, cyc = 0, acc_cyc = 0;
  int          drop_idx = -1, corr_a = -1, corr_b = -1;
  logic [31:0] corr_all = '0, pdata = '0;
  logic [31:0] h_addr, h_data;
  op_t         op;

  always @(negedge clk) begin
    cyc++;
    rvalid = 1'b0;
    if (pend) begin
      rvalid = 1'b1;
      rdata  = pdata;
      pend   = 1'b0;
    end
    if (tmo_watch && err_count != 16'd0) begin
      check("timeout_latency", 64'(cyc - acc_cyc), 64'd65);
      tmo_watch = 1'b0;
    end
    stall = 1'b0;
    if (in_req) begin
      check("req_held", 64'(wreq | rreq), 64'd1);
      check("addr_stable", wreq ? waddr : raddr, h_addr);
      if (wreq) check("wdata_stable", wdata, h_data);
    end else if (wreq || rreq) begin
      in_req     = 1'b1;
      req_num++;
      stall_left = (stall_en && (req_num % 4 == 0)) ? 3 : 0;
      h_addr     = wreq ? waddr : raddr;
      h_data     = wdata;
    end
    if (in_req) begin
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        in_req = 1'b0;
        check("sb_not_empty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          op = sb.pop_front();
          check("op_kind", 64'(wreq), 64'(op.is_wr));
          check("req_addr", wreq ? waddr : raddr, op.addr);
          if (wreq) begin
            check("wdata", wdata, op.data);
            check("wsel", 64'(sel), 64'hF);
            mem[waddr] = wdata;
          end else begin
            if (rd_cnt == drop_idx) begin
              acc_cyc   = cyc;
              tmo_watch = 1'b1;
            end else begin
              pend  = 1'b1;
              pdata = mem[raddr] ^ corr_all ^
                      (((rd_cnt == corr_a) || (rd_cnt == corr_b)) ? 32'h1 : 32'h0);
            end
            rd_cnt++;
          end
        end
      end
    end
  end

  // Single-entry instance: never stalls, answers the cycle after a read.
  logic [31:0] mem1 = '0, w1_addr = '0, w1_data = '0;
  bit          pend1 = 1'b0;

  always @(negedge clk) begin
    rvalid1 = 1'b0;
    if (pend1) begin
      rvalid1 = 1'b1;
      rdata1  = mem1;
      pend1   = 1'b0;
    end
    if (wreq1) begin
      mem1    = wdata1;
      w1_addr = waddr1;
      w1_data = wdata1;
    end
    if (rreq1) pend1 = 1'b1;
  end

  task automatic run(input bit burst);
    sb.delete();
    push_run(burst);
    rd_cnt  = 0;
    req_num = 0;
    @(negedge clk);
    mode  = burst;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_done_clr", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic check_status(input string tag, input logic exp_pass,
                              input logic [15:0] exp_err, input logic [15:0] exp_ff);
    check({tag, "_pass"}, 64'(pass), 64'(exp_pass));
    check({tag, "_err"}, 64'(err_count), 64'(exp_err));
    check({tag, "_ffidx"}, 64'(ff_idx), 64'(exp_ff));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_single(input string tag);
    check({tag, "_n1_done"}, 64'(done1), 64'd1);
    check({tag, "_n1_pass"}, 64'(pass1), 64'd1);
    check({tag, "_n1_addr"}, w1_addr, 64'h100);
    check({tag, "_n1_data"}, w1_data, 64'(SEED));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_wreq", 64'(wreq), 64'd0);
    check("rst_rreq", 64'(rreq), 64'd0);
    check("rst_waddr", waddr, 64'd0);
    check("rst_wdata", wdata, 64'd0);
    check("rst_raddr", raddr, 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_ffidx", 64'(ff_idx), 64'hFFFF);
    rst = 1'b0;

    // Interleaved, zero latency; a start pulse mid-run must be ignored.
    run(1'b0);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1000);
    check_status("ilv", 1'b1, 16'd0, 16'hFFFF);
    check_single("ilv");

    // Burst with a 3-cycle stall on every 4th request.
    stall_en = 1'b1;
    run(1'b1);
    wait_done(1000);
    check_status("burst_stall", 1'b1, 16'd0, 16'hFFFF);
    check_single("burst");
    stall_en = 1'b0;

    // Bit 0 corrupted on reads 5 and 9.
    corr_a = 5;
    corr_b = 9;
    run(1'b0);
    wait_done(1000);
    check_status("corrupt", 1'b0, 16'd2, 16'd5);
    corr_a = -1;
    corr_b = -1;

    // Upper half corrupted: masked instance ignores it, full-mask one does not.
    corr_all = 32'hFFFF_0000;
    run(1'b1);
    wait_done(1000);
    check_status("hi_corrupt", 1'b0, 16'd16, 16'd0);
    check("mask_hi_pass", 64'(m_pass), 64'd1);
    check("mask_hi_err", 64'(m_err_count), 64'd0);
    corr_all = 32'h0000_0100;
    run(1'b1);
    wait_done(1000);
    check("mask_b8_pass", 64'(m_pass), 64'd0);
    check("mask_b8_err", 64'(m_err_count), 64'd16);
    check("mask_b8_ffidx", 64'(m_ff_idx), 64'd0);
    corr_all = '0;

    // Read 3 never answered: scored as a timeout, run continues.
    drop_idx = 3;
    run(1'b0);
    wait_done(1000);
    check_status("timeout", 1'b0, 16'd1, 16'd3);
    check("timeout_seen", 64'(tmo_watch), 64'd0);
    drop_idx = -1;

    // Reset during the burst write phase, then a clean rerun.
    run(1'b1);
    n = 0;
    while (!(wreq && waddr == 32'h70) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx7", 64'(wreq && waddr == 32'h70), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_wreq", 64'(wreq), 64'd0);
    check("midrst_rreq", 64'(rreq), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    run(1'b1);
    wait_done(1000);
    check_status("rerun", 1'b1, 16'd0, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_seq_tester.md
Name: dcache_seq_tester

Overview:
- Synthesizable, parametrised traffic generator and checker for Dcache bring-up; stands in for the CPU data port.
- Writes N_ENTRIES pseudo-random words to a strided address range, reads them back, compares, and reports pass/fail and an error count.
- Two modes: interleaved (write one, read one) and burst (write all, then read all).
- Honours a cache stall and read-valid handshake, so miss/refill paths are exercised as well as hits.

Parameters:
- DATA_W, 32, data width; byte lanes = DATA_W/8.
- ADDR_W, 32, address width.
- N_ENTRIES, 16, words per test run (≥1).
- ADDR_BASE, 0, address of entry 0.
- ADDR_STRIDE, 16, byte stride between entries (one line per entry by default).
- SEL_MASK, all ones (DATA_W/8 bits), byte enables driven on every request; only these bytes are compared.
- LFSR_SEED, 32'hACE1_2345, non-zero data generator seed.
- RD_TIMEOUT, 64, max cycles from read acceptance to rvalid before the read is scored as an error.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse that begins a run; ignored unless idle or done.
- mode_i  in  1  0 = interleaved, 1 = burst; sampled on start_i.
- dcache_stall_i  in  1  cache busy; the current request is held while high.
- dcache_rvalid_i  in  1  read data valid.
- dcache_data_i  in  DATA_W  read data.
- dcache_waddr_o  out  ADDR_W  write address.
- dcache_wdata_o  out  DATA_W  write data.
- dcache_wreq_o  out  1  write request.
- dcache_raddr_o  out  ADDR_W  read address.
- dcache_rreq_o  out  1  read request.
- dcache_sel_o  out  DATA_W/8  byte enables.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until next start_i or rst.
- pass_o  out  1  valid with done_o; 1 if err_count_o == 0.
- err_count_o  out  16  mismatches plus timeouts; saturates at 16'hFFFF.
- first_fail_idx_o  out  16  index of first failure; 16'hFFFF if none.

Behaviour:
- Reset values:
  - All request outputs, addresses, wdata and sel are 0.
  - busy_o, done_o and pass_o are 0.
  - err_count_o is 0 and first_fail_idx_o is 16'hFFFF.
  - State is IDLE, LFSR is loaded with LFSR_SEED, index is 0.
  - Reset mid-run aborts at once: requests drop the next edge and nothing is reported.
- Address and data:
  - Entry i address = ADDR_BASE + i*ADDR_STRIDE, truncated to ADDR_W.
  - Data is a 32-bit Galois LFSR (taps 32,22,2,1), replicated or truncated to DATA_W, and advanced once per write acceptance.
  - Expected read data comes from a second LFSR instance: reseeded on start, advanced once per read completion. No data array is stored.
- Handshake:
  - A request (wreq or rreq) is accepted on a cycle where the request is high and dcache_stall_i is low.
  - While stalled, the request and its addr/data/sel hold stable.
  - The request drops the cycle after acceptance; at most one request is outstanding.
- Read completion:
  - The first dcache_rvalid_i after read acceptance completes the read; the compare happens on that edge.
  - Compare: (data_i ^ expected) masked by SEL_MASK bytes, zero means match.
  - rvalid on the acceptance cycle itself is ignored.
  - If rvalid_i does not arrive within RD_TIMEOUT cycles, score one error and move on.
- FSM states: IDLE, WR, RD, RWAIT, DONE.
  - IDLE or DONE: start_i → WR with index 0; counters cleared, done_o cleared, busy_o set.
  - WR accepted:
    - Interleaved mode → RD for the same index.
    - Burst mode → WR for index+1, or, after the last index, → RD for index 0 (index reset).
  - RD accepted → RWAIT.
  - RWAIT complete or timeout:
    - Interleaved mode → WR for index+1.
    - Burst mode → RD for index+1.
    - After the last index → DONE.
  - DONE: busy_o = 0, done_o = 1, pass_o valid.
- Error recording: on every error, err_count_o increments (saturating); first_fail_idx_o latches the index only if it is still 16'hFFFF.
- Boundaries:
  - N_ENTRIES = 1 works in both modes.
  - start_i while busy is ignored.
  - Stall asserted for an unbounded time hangs legitimately; there is no write timeout.
  - Index counter is $clog2(N_ENTRIES+1) bits wide; there is no wrap inside a run.

Decomposition:
- Shared package dcache_tb_pkg:
  - State enum.
  - LFSR taps and LFSR_SEED default.
  - Byte-mask compare function.
- Sub-module lfsr32 (clk, rst, load, seed, step, q), instantiated twice: generator and checker.

Test Plan:
- Interleaved, zero-latency model (rvalid the cycle after rreq, no stall), N_ENTRIES=16 → done_o after 16 write/read pairs; pass_o=1, err_count_o=0, first_fail_idx_o=16'hFFFF.
- Burst, model stalls 3 cycles on every 4th request → 16 writes at addresses 0x000–0x0F0, then 16 reads in the same order; addr/wdata stable while stalled; pass_o=1.
- Model corrupts bit 0 of read index 5 and index 9 → err_count_o=2, first_fail_idx_o=5, pass_o=0.
- SEL_MASK=4'b0011, model corrupts bits 31:16 of every read → pass_o=1; corrupting bit 8 instead → err_count_o=16.
- Model never returns rvalid for index 3, RD_TIMEOUT=64 → index 3 scored after 64 cycles, run continues, err_count_o=1, first_fail_idx_o=3.
- rst asserted during burst write phase at index 7 → next cycle all requests 0, busy_o=0, done_o=0; a fresh start_i reruns from index 0 with identical data.
